// File: rtl/coin_pulse_encoder_pkg.sv
// Shared definitions for the coin front end: FSM state encoding and
// the denomination codes carried from the classifier to the strobe outputs.
package coin_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_JAM     = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_HALF = 2'd1,
    COIN_ONE  = 2'd2,
    COIN_REJ  = 2'd3
  } coin_code_e;

endpackage

// File: rtl/coin_pulse_encoder_if.sv
// Sensor/strobe bundle between the coin front end and the vending FSM.
// Build with COIN_STATS_EN defined to carry the coin statistics counters.
interface coin_pulse_encoder_if;

  logic coin_raw;
  logic coin_en;
  logic pi_money_half;
  logic pi_money_one;
  logic coin_reject;
  logic busy;
`ifdef COIN_STATS_EN
  logic [15:0] half_cnt;
  logic [15:0] one_cnt;
  logic [15:0] rej_cnt;
`endif

`ifdef COIN_STATS_EN
  modport master (
    output coin_raw, coin_en,
    input  pi_money_half, pi_money_one, coin_reject, busy,
    input  half_cnt, one_cnt, rej_cnt
  );
  modport slave (
    input  coin_raw, coin_en,
    output pi_money_half, pi_money_one, coin_reject, busy,
    output half_cnt, one_cnt, rej_cnt
  );
`else
  modport master (
    output coin_raw, coin_en,
    input  pi_money_half, pi_money_one, coin_reject, busy
  );
  modport slave (
    input  coin_raw, coin_en,
    output pi_money_half, pi_money_one, coin_reject, busy
  );
`endif

endinterface

// File: rtl/coin_pulse_encoder_debounce.sv
// Two-flop synchroniser followed by a counting debouncer: coin_db follows the
// synchronised level only after DB_CNT consecutive samples disagree with it.
module coin_debounce #(
  parameter int DB_CNT = 10,
  parameter int CNT_W  = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic coin_raw,
  output logic coin_db
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] db_cnt;

  // Stage p0/p1: metastability filter on the asynchronous sensor line
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= coin_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: a sample equal to coin_db restarts the run
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt  <= '0;
      coin_db <= 1'b0;
    end else if (sync_p1 == coin_db) begin
      db_cnt <= '0;
    end else if (db_cnt >= DB_LAST) begin
      db_cnt  <= '0;
      coin_db <= sync_p1;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/coin_pulse_encoder.sv
// Coin sensor front end: debounce, width measurement, classification and
// one-cycle denomination strobes. COIN_STATS_EN adds saturating coin counters.
module coin_pulse_encoder
  import coin_pkg::*;
#(
  parameter int DB_CNT   = 10,
  parameter int HALF_MIN = 50,
  parameter int HALF_MAX = 149,
  parameter int ONE_MIN  = 150,
  parameter int ONE_MAX  = 400,
  parameter int LOCKOUT  = 100,
  parameter int CNT_W    = 16
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  coin_pulse_encoder_if.slave  bus
);

  if (!(HALF_MIN <= HALF_MAX && HALF_MAX < ONE_MIN && ONE_MIN <= ONE_MAX)) begin : g_bad_order
    $error("coin_pulse_encoder: width windows must satisfy HALF_MIN <= HALF_MAX < ONE_MIN <= ONE_MAX");
  end
  if (LOCKOUT < 1 || DB_CNT < 1 || (ONE_MAX + 1) >= (1 << CNT_W) || LOCKOUT >= (1 << CNT_W)) begin : g_bad_size
    $error("coin_pulse_encoder: CNT_W too small or LOCKOUT/DB_CNT zero");
  end

  localparam logic [CNT_W-1:0] HALF_MIN_C  = CNT_W'(HALF_MIN);
  localparam logic [CNT_W-1:0] HALF_MAX_C  = CNT_W'(HALF_MAX);
  localparam logic [CNT_W-1:0] ONE_MIN_C   = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] ONE_MAX_C   = CNT_W'(ONE_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST_C = CNT_W'(LOCKOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic coin_code_e classify(input logic [CNT_W-1:0] w, input logic ok);
    if (!ok)                                return COIN_REJ;
    if (w >= HALF_MIN_C && w <= HALF_MAX_C) return COIN_HALF;
    if (w >= ONE_MIN_C && w <= ONE_MAX_C)   return COIN_ONE;
    return COIN_REJ;
  endfunction

  logic             coin_db;
  logic             db_prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] wid;
  logic [CNT_W-1:0] lock_cnt;
  logic             en_ok;
  coin_code_e       res_code;

  coin_debounce #(
    .DB_CNT (DB_CNT),
    .CNT_W  (CNT_W)
  ) u_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .coin_raw  (bus.coin_raw),
    .coin_db   (coin_db)
  );

  // FSM stage: result code is registered, so strobes land one cycle after the edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      db_prev  <= 1'b0;
      wid      <= '0;
      lock_cnt <= '0;
      en_ok    <= 1'b0;
      res_code <= COIN_NONE;
    end else begin
      db_prev  <= coin_db;
      res_code <= COIN_NONE;
      case (state)
        ST_IDLE: begin
          if (coin_db && !db_prev) begin
            state <= ST_MEASURE;
            wid   <= CNT_W'(1);
            en_ok <= bus.coin_en;
          end
        end
        ST_MEASURE: begin
          if (coin_db) begin
            wid <= sat_inc(wid);
            if (wid >= ONE_MAX_C) begin
              state    <= ST_JAM;
              res_code <= COIN_REJ;
            end
          end else begin
            res_code <= classify(wid, en_ok && bus.coin_en);
            state    <= ST_LOCKOUT;
            lock_cnt <= '0;
          end
        end
        ST_JAM: begin
          if (!coin_db) begin
            state    <= ST_LOCKOUT;
            lock_cnt <= '0;
          end
        end
        ST_LOCKOUT: begin
          // A coin still covering the sensor when the dead time ends is swallowed
          if (lock_cnt >= LOCK_LAST_C) begin
            if (!coin_db) state <= ST_IDLE;
          end else begin
            lock_cnt <= sat_inc(lock_cnt);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pi_money_half = (res_code == COIN_HALF);
  assign bus.pi_money_one  = (res_code == COIN_ONE);
  assign bus.coin_reject   = (res_code == COIN_REJ);
  assign bus.busy          = (state != ST_IDLE);

`ifdef COIN_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [15:0] half_cnt;
  logic [15:0] one_cnt;
  logic [15:0] rej_cnt;

  // Statistics stage: counts the registered strobes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      half_cnt <= '0;
      one_cnt  <= '0;
      rej_cnt  <= '0;
    end else begin
      if (res_code == COIN_HALF) half_cnt <= sat_inc16(half_cnt);
      if (res_code == COIN_ONE)  one_cnt  <= sat_inc16(one_cnt);
      if (res_code == COIN_REJ)  rej_cnt  <= sat_inc16(rej_cnt);
    end
  end

  assign bus.half_cnt = half_cnt;
  assign bus.one_cnt  = one_cnt;
  assign bus.rej_cnt  = rej_cnt;
`endif

endmodule

// File: tb/tb_coin_pulse_encoder.sv
// Randomised and directed bench for coin_pulse_encoder: strobes are compared
// against an event-level model of coin widths, enables and fixed latencies.
module tb_coin_pulse_encoder;

  localparam int DB_CNT   = 10;
  localparam int HALF_MIN = 50;
  localparam int HALF_MAX = 149;
  localparam int ONE_MIN  = 150;
  localparam int ONE_MAX  = 400;
  localparam int LOCKOUT  = 100;
  localparam int CNT_W    = 16;
  localparam int LAT      = DB_CNT + 3;
  localparam int GAP      = 140;

  localparam logic [2:0] EV_HALF = 3'b100;
  localparam logic [2:0] EV_ONE  = 3'b010;
  localparam logic [2:0] EV_REJ  = 3'b001;

  typedef struct {
    logic [2:0] code;
    int         cyc;
  } ev_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   busy_fall = -1;
  logic busy_prev = 1'b0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];

  coin_pulse_encoder_if bus ();

  coin_pulse_encoder #(
    .DB_CNT   (DB_CNT),
    .HALF_MIN (HALF_MIN),
    .HALF_MAX (HALF_MAX),
    .ONE_MIN  (ONE_MIN),
    .ONE_MAX  (ONE_MAX),
    .LOCKOUT  (LOCKOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Observe strobes away from the active edge
  always @(negedge sys_clk) begin
    ev_t e;
    if (bus.pi_money_half || bus.pi_money_one || bus.coin_reject) begin
      e.code = {bus.pi_money_half, bus.pi_money_one, bus.coin_reject};
      e.cyc  = cyc;
      obs_q.push_back(e);
      check_val("busy_at_strobe", int'(bus.busy), 1);
    end
    if (busy_prev && !bus.busy) busy_fall = cyc;
    busy_prev = bus.busy;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Reference: glitches shorter than DB_CNT are invisible, so the measured
  // width is simply the span between the stable rise and the final fall.
  task automatic predict(input int r, input int f, input bit en_r, input bit en_f);
    ev_t e;
    int  w;
    w = f - r;
    if (w > ONE_MAX) begin
      e.code = EV_REJ;
      e.cyc  = r + LAT + ONE_MAX;
    end else begin
      e.cyc = f + LAT;
      if (!en_r || !en_f)                    e.code = EV_REJ;
      else if (w >= HALF_MIN && w <= HALF_MAX) e.code = EV_HALF;
      else if (w >= ONE_MIN && w <= ONE_MAX)   e.code = EV_ONE;
      else                                     e.code = EV_REJ;
    end
    exp_q.push_back(e);
  endtask

  task automatic run_coin(input int w, input bit gl, input bit en_r, input bit en_f,
                          input bit ignored, input int gap, output int f);
    int r;
    bus.coin_en = en_r;
    if (gl) begin
      bus.coin_raw = 1'b1; step(3);
      bus.coin_raw = 1'b0; step(3);
    end
    r = cyc;
    bus.coin_raw = 1'b1;
    step(w);
    if (gl) begin
      bus.coin_raw = 1'b0; step(3);
      bus.coin_raw = 1'b1; step(3);
    end
    f = cyc;
    bus.coin_raw = 1'b0;
    bus.coin_en  = en_f;
    if (!ignored) predict(r, f, en_r, en_f);
    step(gap);
  endtask

  task automatic compare_events(input string tag);
    ev_t o, e;
    check_val({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_val({tag, "_code"}, int'(o.code), int'(e.code));
      check_val({tag, "_cyc"}, o.cyc, e.cyc);
    end
    obs_q.delete();
    exp_q.delete();
    check_val({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int f, f2, w;
    bit gl, en_r, en_f;
    bus.coin_raw = 1'b0;
    bus.coin_en  = 1'b0;
    step(3);
    check_val("rst_half", int'(bus.pi_money_half), 0);
    check_val("rst_one",  int'(bus.pi_money_one), 0);
    check_val("rst_rej",  int'(bus.coin_reject), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    sys_rst_n = 1'b1;
    step(5);
    check_val("post_rst_busy", int'(bus.busy), 0);

    // Clean half coin and busy release timing
    run_coin(100, 0, 1, 1, 0, GAP, f);
    check_val("busy_fall", busy_fall, f + LAT + LOCKOUT);
    compare_events("half100");

    run_coin(250, 0, 1, 1, 0, GAP, f); compare_events("one250");
    run_coin(149, 0, 1, 1, 0, GAP, f); compare_events("half149");
    run_coin(150, 0, 1, 1, 0, GAP, f); compare_events("one150");
    run_coin(400, 0, 1, 1, 0, GAP, f); compare_events("one400");
    run_coin(49,  0, 1, 1, 0, GAP, f); compare_events("rej49");
    run_coin(500, 0, 1, 1, 0, GAP, f); compare_events("jam500");
    run_coin(100, 1, 1, 1, 0, GAP, f); compare_events("glitch100");
    run_coin(250, 0, 1, 0, 0, GAP, f); compare_events("en_fall0");

    // Disabled coin followed by a second coin inside the lockout window
    run_coin(250, 0, 0, 0, 0, 10, f);
    run_coin(120, 0, 1, 1, 1, GAP, f2);
    check_val("lock_busy_fall", busy_fall, f2 + DB_CNT + 3);
    compare_events("lockout");

    // Asynchronous reset in the middle of a measurement
    bus.coin_en  = 1'b1;
    bus.coin_raw = 1'b1;
    step(60);
    #2 sys_rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", int'(bus.busy), 0);
    check_val("mid_rst_strobes",
              int'({bus.pi_money_half, bus.pi_money_one, bus.coin_reject}), 0);
    bus.coin_raw = 1'b0;
    step(5);
    sys_rst_n = 1'b1;
    step(GAP);
    compare_events("mid_rst");
`ifdef COIN_STATS_EN
    check_val("stats_rst_half", int'(bus.half_cnt), 0);
    check_val("stats_rst_one",  int'(bus.one_cnt), 0);
    check_val("stats_rst_rej",  int'(bus.rej_cnt), 0);
    run_coin(100, 0, 1, 1, 0, GAP, f);
    compare_events("stats_coin");
    check_val("stats_half", int'(bus.half_cnt), 1);
    check_val("stats_one",  int'(bus.one_cnt), 0);
    check_val("stats_rej",  int'(bus.rej_cnt), 0);
`endif

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       w = $urandom_range(HALF_MIN - 5, HALF_MAX + 5);
        1:       w = $urandom_range(ONE_MAX - 5, ONE_MAX + 15);
        default: w = $urandom_range(20, 450);
      endcase
      gl   = 1'($urandom_range(0, 1));
      en_r = ($urandom_range(0, 7) != 0);
      en_f = ($urandom_range(0, 7) != 0);
      run_coin(w, gl, en_r, en_f, 0, GAP, f);
      compare_events("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coin_pulse_encoder.md
Name: coin_pulse_encoder

Overview:
- Front end of the vending path. Converts one raw coin-sensor line into the single-cycle pi_money_half / pi_money_one strobes that the vending state machine consumes.
- The sensor pulse width encodes the denomination. This block synchronises, debounces and measures that width, then classifies the coin and emits exactly one strobe per valid coin.
- Invalid or jammed coins are rejected.

Parameters:
- DB_CNT, 10: consecutive identical synchronised samples required before the debounced level changes.
- HALF_MIN, 50: minimum debounced-high width (cycles) for a 0.5 coin.
- HALF_MAX, 149: maximum width for a 0.5 coin.
- ONE_MIN, 150: minimum width for a 1.0 coin.
- ONE_MAX, 400: maximum width for a 1.0 coin; above this the coin is treated as a jam.
- LOCKOUT, 100: dead cycles after each coin event.
- CNT_W, 16: width of the measurement and lockout counters; must hold ONE_MAX+1 and LOCKOUT.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- coin_raw  in  1  raw, asynchronous, bouncy sensor level; high while a coin passes.
- coin_en  in  1  accept enable (vending side not inhibiting).
- pi_money_half  out  1  one-cycle strobe: valid 0.5 coin.
- pi_money_one  out  1  one-cycle strobe: valid 1.0 coin.
- coin_reject  out  1  one-cycle strobe: coin rejected (bad width, jam, or disabled).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0, sync flops 0, debounced level 0, counters 0, FSM in IDLE. Reset mid-measurement drops the coin silently; no strobe.
- Input path:
  - 2-FF synchroniser on coin_raw.
  - Debouncer: coin_db takes the new value after DB_CNT consecutive equal samples that differ from the current coin_db.
  - Any mismatch restarts the count.
- FSM states IDLE, MEASURE, JAM, LOCKOUT:
  - IDLE: on a coin_db rising edge go to MEASURE, wid=1, and latch en_ok=coin_en. Otherwise stay.
  - MEASURE: while coin_db=1, wid increments by 1 per cycle.
    - If wid reaches ONE_MAX+1: go to JAM and pulse coin_reject that cycle.
    - On coin_db falling edge: classify, emit the result in the next cycle, then go to LOCKOUT.
  - JAM: wait for coin_db=0, then go to LOCKOUT. No additional strobe.
  - LOCKOUT: count LOCKOUT cycles. Then go to IDLE only if coin_db=0; otherwise hold in LOCKOUT. Edges during LOCKOUT are ignored.
- Classification at the falling edge:
  - en_ok=0, or coin_en=0 at the falling edge → coin_reject.
  - HALF_MIN ≤ wid ≤ HALF_MAX → pi_money_half.
  - ONE_MIN ≤ wid ≤ ONE_MAX → pi_money_one.
  - Any other width → coin_reject.
- Output timing:
  - Latency from the debounced falling edge to a strobe is 1 cycle.
  - Total latency from coin_raw falling is 2 (sync) + DB_CNT + 1 cycles.
- Invariants:
  - pi_money_half, pi_money_one and coin_reject are mutually exclusive, each at most one cycle per coin.
  - A strobe never fires while in IDLE.
  - Counters saturate and never wrap.
  - Parameter ordering HALF_MIN ≤ HALF_MAX < ONE_MIN ≤ ONE_MAX is required; an elaboration-time check fails otherwise.

Optional Feature:
- Macro: COIN_STATS_EN.
- Defined: adds outputs half_cnt[15:0], one_cnt[15:0] and rej_cnt[15:0].
  - Each increments on its corresponding strobe.
  - Each saturates at 16'hFFFF.
  - All cleared by reset.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package coin_pkg:
  - FSM state encoding (IDLE=2'd0, MEASURE=2'd1, JAM=2'd2, LOCKOUT=2'd3).
  - Denomination code constants (COIN_NONE, COIN_HALF, COIN_ONE, COIN_REJ).
- One sub-module, coin_debounce: synchroniser plus DB_CNT debouncer, producing coin_db.
- Classification, FSM and strobes stay in the top module.

Test Plan:
- Clean pulse of 100 cycles, coin_en=1 → exactly one pi_money_half, DB_CNT+3 cycles after coin_raw falls; busy returns low LOCKOUT cycles later.
- Clean pulse of 250 cycles → one pi_money_one; boundary widths 149 / 150 / 400 / 49 → half / one / one / reject respectively.
- Pulse of 500 cycles → coin_reject at debounced width 401, nothing at release; FSM passes JAM → LOCKOUT → IDLE.
- 100-cycle pulse with 3-cycle glitches at both edges (glitch < DB_CNT) → still a single pi_money_half; no extra strobes.
- coin_en=0 at rising edge, pulse 250 → coin_reject only; a second coin arriving during LOCKOUT is ignored entirely.
- sys_rst_n asserted mid-MEASURE → all outputs 0 immediately; no strobe after release. Under COIN_STATS_EN, counters read 0 after reset and 1 after one valid coin.
